ptw_read_responder: RTL and testbench

// - Responder end of the read-only page-table-walk memory protocol (request/addr/rlen/ack/rvalid/rdata).
// - Serves N_PORTS walker initiators (e.g. ITLB and DTLB walkers) and merges them onto one backing read bus.
// - Returns exactly one in-order response for every acked request, including requests the walker later aborts.

---
 rtl/ptw_read_responder.sv | 137 +++++++++++++
 tb/tb_ptw_read_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_read_responder.sv
// ptw_read_responder: merges N_PORTS page-table-walk read initiators onto one in-order backing bus.
// Define PTW_RANGE_CHECK_EN to answer out-of-range walks locally with an all-zero (invalid) PTE.
module ptw_read_responder #(
    parameter int          N_PORTS         = 2,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [29:0] RANGE_BASE      = 30'h0,
    parameter logic [29:0] RANGE_MASK      = 30'h3FF00000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_PORTS-1:0]       i_req_request,
    input  logic [N_PORTS-1:0][29:0] i_req_addr,
    input  logic [N_PORTS-1:0][4:0]  i_req_rlen,
    output logic [N_PORTS-1:0]       o_req_ack,
    output logic [N_PORTS-1:0]       o_req_rvalid,
    output logic [31:0]              o_req_rdata,
    output logic                     o_bus_request,
    output logic [29:0]              o_bus_addr,
    input  logic                     i_bus_ack,
    input  logic                     i_bus_rvalid,
    input  logic [31:0]              i_bus_rdata
);

    localparam int PW = $clog2(N_PORTS);
    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [AW:0]   DEPTH    = (AW+1)'(MAX_OUTSTANDING);
    localparam logic [AW-1:0] LAST_PTR = AW'(MAX_OUTSTANDING - 1);

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_PORTS) s = s - N_PORTS;
        return PW'(s);
    endfunction

    logic [PW-1:0]      r_fifo [MAX_OUTSTANDING];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic [PW-1:0]      r_rr_ptr;
    logic [N_PORTS-1:0] r_rvalid;
    logic [31:0]        r_rdata;

    logic [PW-1:0] w_sel;
    logic          w_any;
    logic          w_full;
    logic          w_empty;
    logic          w_in_range;
    logic          w_bus_acc;
    logic          w_local_acc;
    logic          w_pop;
    logic          w_unused_rlen;

    assign w_unused_rlen = ^i_req_rlen;

    // Rotating priority: the port after the last one granted is searched first.
    // NOTE: every combinational output gets a default before the loop so no latch is inferred.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (!w_any && i_req_request[wrap_idx(r_rr_ptr, i)]) begin
                w_any = 1'b1;
                w_sel = wrap_idx(r_rr_ptr, i);
            end
        end
    end

`ifdef PTW_RANGE_CHECK_EN
    assign w_in_range = (i_req_addr[w_sel] & RANGE_MASK) == RANGE_BASE;
`else
    assign w_in_range = 1'b1;
`endif

    // Full comes from the registered count, so a same-cycle pop never frees a slot early.
    assign w_full        = (r_count == DEPTH);
    assign w_empty       = (r_count == '0);
    assign o_bus_request = w_any & ~w_full & w_in_range;
    assign o_bus_addr    = i_req_addr[w_sel];
    assign w_bus_acc     = o_bus_request & i_bus_ack;
    // Out-of-range walks wait for an empty FIFO so their zero PTE stays behind in-flight reads.
    assign w_local_acc   = w_any & ~w_in_range & w_empty;
    assign w_pop         = i_bus_rvalid & ~w_empty;

    always_comb begin
        o_req_ack = '0;
        if (w_bus_acc || w_local_acc) o_req_ack[w_sel] = 1'b1;
    end

    // NOTE: the ID storage carries no reset; only pointers and count decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_bus_acc) r_fifo[r_wr_ptr] <= w_sel;
    end

    // NOTE: state uses non-blocking assignments so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr_ptr <= '0;
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= '0;
            if (w_bus_acc) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            unique case ({w_bus_acc, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            if (w_bus_acc || w_local_acc) r_rr_ptr <= wrap_idx(w_sel, 1);
            // A local ack only happens with an empty FIFO, so it never collides with a pop.
            if (w_pop) begin
                r_rvalid[r_fifo[r_rd_ptr]] <= 1'b1;
                r_rdata                    <= i_bus_rdata;
            end else if (w_local_acc) begin
                r_rvalid[w_sel] <= 1'b1;
                r_rdata         <= 32'h0;
            end
        end
    end

    assign o_req_rvalid = r_rvalid;
    assign o_req_rdata  = r_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(i_bus_rvalid && w_empty))
                else $error("ptw_read_responder: bus_rvalid with no outstanding read");
            assert ((RANGE_BASE & ~RANGE_MASK) == 30'h0)
                else $error("ptw_read_responder: RANGE_BASE has bits outside RANGE_MASK");
        end
    end

endmodule

// File: tb/tb_ptw_read_responder.sv
// Directed bench for ptw_read_responder: table-driven basic/round-robin vectors plus
// hand sequences for full, abort, reset and (with PTW_RANGE_CHECK_EN) range-check behaviour.
module tb_ptw_read_responder;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_request;
    logic [1:0][29:0] req_addr;
    logic [1:0][4:0]  req_rlen;
    logic [1:0]       req_ack;
    logic [1:0]       req_rvalid;
    logic [31:0]      req_rdata;
    logic             bus_request;
    logic [29:0]      bus_addr;
    logic             bus_ack;
    logic             bus_rvalid;
    logic [31:0]      bus_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ptw_read_responder #(
        .N_PORTS(2),
        .MAX_OUTSTANDING(4),
        .RANGE_BASE(30'h0),
        .RANGE_MASK(30'h3FF00000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_request(req_request),
        .i_req_addr   (req_addr),
        .i_req_rlen   (req_rlen),
        .o_req_ack    (req_ack),
        .o_req_rvalid (req_rvalid),
        .o_req_rdata  (req_rdata),
        .o_bus_request(bus_request),
        .o_bus_addr   (bus_addr),
        .i_bus_ack    (bus_ack),
        .i_bus_rvalid (bus_rvalid),
        .i_bus_rdata  (bus_rdata)
    );

    typedef struct {
        logic [1:0]  req;
        logic        b_ack;
        logic        b_rvalid;
        logic [31:0] b_rdata;
        logic [1:0]  e_ack;
        logic        e_breq;
        logic [29:0] e_baddr;
        logic [1:0]  e_rvalid;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic b_ack, input logic b_rv, input logic [31:0] b_data);
        req_request = req;
        bus_ack     = b_ack;
        bus_rvalid  = b_rv;
        bus_rdata   = b_data;
    endtask

    // Drive one cycle of request inputs, check the combinational accept outputs, advance a cycle.
    task automatic req_cycle(input string name, input logic [1:0] req, input logic b_ack,
                             input logic [1:0] e_ack, input logic e_breq);
        drive(req, b_ack, 1'b0, 32'h0);
        #1;
        check({name, " ack"}, 32'(req_ack), 32'(e_ack));
        check({name, " bus_request"}, 32'(bus_request), 32'(e_breq));
        @(negedge clk);
    endtask

    // One bus response cycle; the routed response is checked in the following cycle.
    task automatic pop_check(input string name, input logic [31:0] data, input logic [1:0] e_rv);
        drive(2'b00, 1'b0, 1'b1, data);
        @(negedge clk);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        #1;
        check({name, " rvalid"}, 32'(req_rvalid), 32'(e_rv));
        check({name, " rdata"}, req_rdata, data);
        @(negedge clk);
    endtask

    initial begin
        // Single read, then alternating grants with simultaneous push/pop and in-order routing.
        //           req    ack  rv   rdata          e_ack  breq baddr    e_rv   e_rdata
        vecs[0]  = '{2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 30'h100, 2'b00, 32'h0};
        vecs[1]  = '{2'b01, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, 30'h100, 2'b00, 32'h0};
        vecs[2]  = '{2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 30'h100, 2'b00, 32'h0};
        vecs[3]  = '{2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 30'h100, 2'b00, 32'h0};
        vecs[4]  = '{2'b00, 1'b0, 1'b1, 32'hDEADBEEF, 2'b00, 1'b0, 30'h100, 2'b00, 32'h0};
        vecs[5]  = '{2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 30'h100, 2'b01, 32'hDEADBEEF};
        vecs[6]  = '{2'b11, 1'b1, 1'b0, 32'h0,        2'b10, 1'b1, 30'h200, 2'b00, 32'hDEADBEEF};
        vecs[7]  = '{2'b11, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, 30'h100, 2'b00, 32'hDEADBEEF};
        vecs[8]  = '{2'b11, 1'b1, 1'b0, 32'h0,        2'b10, 1'b1, 30'h200, 2'b00, 32'hDEADBEEF};
        vecs[9]  = '{2'b11, 1'b1, 1'b1, 32'h11111111, 2'b01, 1'b1, 30'h100, 2'b00, 32'hDEADBEEF};
        vecs[10] = '{2'b11, 1'b1, 1'b1, 32'h22222222, 2'b10, 1'b1, 30'h200, 2'b10, 32'h11111111};
        vecs[11] = '{2'b00, 1'b0, 1'b1, 32'h33333333, 2'b00, 1'b0, 30'h100, 2'b01, 32'h22222222};
        vecs[12] = '{2'b00, 1'b0, 1'b1, 32'h44444444, 2'b00, 1'b0, 30'h100, 2'b10, 32'h33333333};
        vecs[13] = '{2'b00, 1'b0, 1'b1, 32'h55555555, 2'b00, 1'b0, 30'h100, 2'b01, 32'h44444444};
        vecs[14] = '{2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 30'h100, 2'b10, 32'h55555555};
        vecs[15] = '{2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 30'h100, 2'b00, 32'h55555555};

        rst         = 1'b1;
        req_addr[0] = 30'h100;
        req_addr[1] = 30'h200;
        req_rlen    = '{5'd3, 5'd7};
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        check("reset rvalid", 32'(req_rvalid), 32'h0);
        check("reset rdata", req_rdata, 32'h0);
        check("reset ack", 32'(req_ack), 32'h0);
        check("reset bus_request", 32'(bus_request), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].req, vecs[i].b_ack, vecs[i].b_rvalid, vecs[i].b_rdata);
            #1;
            check($sformatf("vec%0d ack", i), 32'(req_ack), 32'(vecs[i].e_ack));
            check($sformatf("vec%0d bus_request", i), 32'(bus_request), 32'(vecs[i].e_breq));
            check($sformatf("vec%0d bus_addr", i), 32'(bus_addr), 32'(vecs[i].e_baddr));
            check($sformatf("vec%0d rvalid", i), 32'(req_rvalid), 32'(vecs[i].e_rvalid));
            check($sformatf("vec%0d rdata", i), req_rdata, vecs[i].e_rdata);
            @(negedge clk);
        end

        // Full: four accepts fill the FIFO; the pop cycle still sees full.
        for (int i = 0; i < 4; i++) req_cycle($sformatf("fill%0d", i), 2'b01, 1'b1, 2'b01, 1'b1);
        req_cycle("full", 2'b01, 1'b1, 2'b00, 1'b0);
        drive(2'b01, 1'b1, 1'b1, 32'h000000A0);
        #1;
        check("full pop-cycle bus_request", 32'(bus_request), 32'h0);
        check("full pop-cycle ack", 32'(req_ack), 32'h0);
        @(negedge clk);
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        #1;
        check("refill bus_request", 32'(bus_request), 32'h1);
        check("refill ack", 32'(req_ack), 32'h1);
        check("refill rvalid", 32'(req_rvalid), 32'h1);
        check("refill rdata", req_rdata, 32'h000000A0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) pop_check($sformatf("drain%0d", i), 32'hA1 + 32'(i), 2'b01);

        // Abort before ack leaves nothing; abort after ack still gets its response.
        drive(2'b10, 1'b0, 1'b0, 32'h0);
        #1;
        check("pre-ack bus_addr", 32'(bus_addr), 32'h200);
        check("pre-ack ack", 32'(req_ack), 32'h0);
        check("pre-ack bus_request", 32'(bus_request), 32'h1);
        @(negedge clk);
        req_cycle("dropped", 2'b00, 1'b1, 2'b00, 1'b0);
        req_cycle("abort p1", 2'b10, 1'b1, 2'b10, 1'b1);
        req_cycle("after abort p0", 2'b01, 1'b1, 2'b01, 1'b1);
        pop_check("aborted resp", 32'hB1B1B1B1, 2'b10);
        pop_check("p0 resp", 32'hB2B2B2B2, 2'b01);

        // Reset with two reads outstanding; a stray response during reset goes nowhere.
        req_cycle("pre-rst0", 2'b01, 1'b1, 2'b01, 1'b1);
        req_cycle("pre-rst1", 2'b01, 1'b1, 2'b01, 1'b1);
        rst = 1'b1;
        drive(2'b00, 1'b0, 1'b1, 32'h000000CC);
        @(negedge clk);
        rst = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        #1;
        check("post-rst rvalid", 32'(req_rvalid), 32'h0);
        check("post-rst rdata", req_rdata, 32'h0);
        @(negedge clk);
        check("post-rst idle rvalid", 32'(req_rvalid), 32'h0);
        req_cycle("post-rst g0", 2'b11, 1'b1, 2'b01, 1'b1);
        req_cycle("post-rst g1", 2'b11, 1'b1, 2'b10, 1'b1);
        req_cycle("post-rst g2", 2'b11, 1'b1, 2'b01, 1'b1);
        req_cycle("post-rst g3", 2'b11, 1'b1, 2'b10, 1'b1);
        req_cycle("post-rst full", 2'b11, 1'b1, 2'b00, 1'b0);
        pop_check("post-rst r0", 32'hC1, 2'b01);
        pop_check("post-rst r1", 32'hC2, 2'b10);
        pop_check("post-rst r2", 32'hC3, 2'b01);
        pop_check("post-rst r3", 32'hC4, 2'b10);

`ifdef PTW_RANGE_CHECK_EN
        // Out-of-range walk: local ack only with an empty FIFO, zero PTE one cycle later.
        req_addr[0] = 30'h10000000;
        req_cycle("range local", 2'b01, 1'b0, 2'b01, 1'b0);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        #1;
        check("range rvalid", 32'(req_rvalid), 32'h1);
        check("range rdata", req_rdata, 32'h0);
        @(negedge clk);
        req_cycle("range inflight", 2'b10, 1'b1, 2'b10, 1'b1);
        req_cycle("range stall0", 2'b01, 1'b1, 2'b00, 1'b0);
        req_cycle("range stall1", 2'b01, 1'b1, 2'b00, 1'b0);
        drive(2'b01, 1'b1, 1'b1, 32'hD1D1D1D1);
        #1;
        check("range pop-cycle ack", 32'(req_ack), 32'h0);
        @(negedge clk);
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        #1;
        check("range inflight rvalid", 32'(req_rvalid), 32'h2);
        check("range inflight rdata", req_rdata, 32'hD1D1D1D1);
        check("range late ack", 32'(req_ack), 32'h1);
        @(negedge clk);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        #1;
        check("range late rvalid", 32'(req_rvalid), 32'h1);
        check("range late rdata", req_rdata, 32'h0);
        @(negedge clk);
        req_addr[0] = 30'h100;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
